// File: rtl/updown_counter_gen2.sv
// updown_counter_gen2: parametrised loadable up/down counter with prescaler,
// wrap/saturate limits, event flags and a registered, gated output stage.
//   clk, rst_n       clock; asynchronous active-low reset
//   en, up_dn        count enable (advances prescaler); 1 = up, 0 = down
//   clear, load      synchronous clear / load of load_val (clear wins)
//   oe               output-stage enable
//   cmp_val          compare value (used only when UPDOWN_CNT_COMPARE_EN is defined)
//   count_q          live counter register
//   count_out        registered, gated copy of count_q; out_valid flags it
//   tc               terminal count for the current direction (combinational)
//   wrap_pulse       one-cycle pulse after a step that wrapped or hit a saturated limit
//   cmp_match        one-cycle pulse after count_q changes to cmp_val (optional)
// Optional feature macro: UPDOWN_CNT_COMPARE_EN.
module updown_counter_gen2 #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             oe,
  input  logic [WIDTH-1:0] cmp_val,
  output logic [WIDTH-1:0] count_q,
  output logic [WIDTH-1:0] count_out,
  output logic             out_valid,
  output logic             tc,
  output logic             wrap_pulse,
  output logic             cmp_match
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0]    pre;
  logic             adv;
  logic             step;
  logic             at_lim;
  logic             hit;
  logic [WIDTH-1:0] cnt_next;

  // at_lim is the limit in the current direction, so it doubles as tc
  always_comb begin
    adv      = en & ~clear & ~load;
    step     = adv & (pre == PRE_LAST);
    at_lim   = up_dn ? &count_q : ~|count_q;
    hit      = step & at_lim;
    cnt_next = clear ? '0 :
               load ? load_val :
               !step ? count_q :
               (hit && SATURATE) ? count_q :
               up_dn ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
  end

  assign tc = at_lim;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      pre        <= '0;
      wrap_pulse <= 1'b0;
      count_out  <= '0;
      out_valid  <= 1'b0;
    end else begin
      count_q    <= cnt_next;
      pre        <= (clear | load) ? '0 : !adv ? pre : (pre == PRE_LAST) ? '0 : pre + PW'(1);
      wrap_pulse <= hit;
      count_out  <= oe ? count_q : '0;
      out_valid  <= oe;
    end
  end

`ifdef UPDOWN_CNT_COMPARE_EN
  // a saturated hold is a step that leaves count_q unchanged, so it must not re-fire
  logic cmp_evt;
  assign cmp_evt = clear | load | (step & ~(hit & SATURATE));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cmp_match <= 1'b0;
    else cmp_match <= cmp_evt & (cnt_next == cmp_val);
  end
`else
  logic unused_cmp;
  assign unused_cmp = ^cmp_val;
  assign cmp_match  = 1'b0;
`endif
endmodule

// File: tb/tb_updown_counter_gen2.sv
// tb_updown_counter_gen2: checks three counter configurations against a behavioural model.
module tb_updown_counter_gen2;
`ifdef UPDOWN_CNT_COMPARE_EN
  localparam bit CMP_ON = 1'b1;
`else
  localparam bit CMP_ON = 1'b0;
`endif
  logic clk, rst_n, en, up_dn, clear, load, oe;
  logic [7:0] load_val, cmp_val;
  logic [2:0][7:0] cq, co;
  logic [2:0] ov, tcv, wp, cm;
  int errs = 0;
  int checks = 0;
  int ps[3] = '{1, 1, 4};
  bit sat[3] = '{1'b0, 1'b1, 1'b0};
  int m_cnt[3], m_pre[3], m_out[3];
  bit m_ov[3], m_wp[3], m_cm[3];

  updown_counter_gen2 #(.WIDTH(8), .PRESCALE(1), .SATURATE(1'b0)) d0 (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clear(clear), .load(load),
    .load_val(load_val), .oe(oe), .cmp_val(cmp_val), .count_q(cq[0]), .count_out(co[0]),
    .out_valid(ov[0]), .tc(tcv[0]), .wrap_pulse(wp[0]), .cmp_match(cm[0]));
  updown_counter_gen2 #(.WIDTH(8), .PRESCALE(1), .SATURATE(1'b1)) d1 (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clear(clear), .load(load),
    .load_val(load_val), .oe(oe), .cmp_val(cmp_val), .count_q(cq[1]), .count_out(co[1]),
    .out_valid(ov[1]), .tc(tcv[1]), .wrap_pulse(wp[1]), .cmp_match(cm[1]));
  updown_counter_gen2 #(.WIDTH(8), .PRESCALE(4), .SATURATE(1'b0)) d2 (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clear(clear), .load(load),
    .load_val(load_val), .oe(oe), .cmp_val(cmp_val), .count_q(cq[2]), .count_out(co[2]),
    .out_valid(ov[2]), .tc(tcv[2]), .wrap_pulse(wp[2]), .cmp_match(cm[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s got=%0d expected=%0d at %0t", n, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // model: prescaler counts enabled cycles; every PRESCALE-th one is a step
  always @(posedge clk or negedge rst_n) begin
    int old_v, new_v;
    bit hit_v;
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        m_cnt[i] = 0; m_pre[i] = 0; m_out[i] = 0;
        m_ov[i] = 0; m_wp[i] = 0; m_cm[i] = 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        old_v = m_cnt[i];
        new_v = old_v;
        hit_v = 0;
        m_out[i] = oe ? old_v : 0;
        m_ov[i] = oe;
        if (clear) begin
          new_v = 0; m_pre[i] = 0;
        end else if (load) begin
          new_v = int'(load_val); m_pre[i] = 0;
        end else if (en) begin
          m_pre[i]++;
          if (m_pre[i] == ps[i]) begin
            m_pre[i] = 0;
            if (up_dn) begin
              if (old_v == 255) begin hit_v = 1; new_v = sat[i] ? 255 : 0; end
              else new_v = old_v + 1;
            end else begin
              if (old_v == 0) begin hit_v = 1; new_v = sat[i] ? 0 : 255; end
              else new_v = old_v - 1;
            end
          end
        end
        m_wp[i] = hit_v;
        m_cm[i] = CMP_ON && (clear || load || new_v != old_v) && new_v == int'(cmp_val);
        m_cnt[i] = new_v;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("count_q[%0d]", i), int'(cq[i]), m_cnt[i]);
      chk($sformatf("count_out[%0d]", i), int'(co[i]), m_out[i]);
      chk($sformatf("out_valid[%0d]", i), int'(ov[i]), int'(m_ov[i]));
      chk($sformatf("wrap_pulse[%0d]", i), int'(wp[i]), int'(m_wp[i]));
      chk($sformatf("cmp_match[%0d]", i), int'(cm[i]), int'(m_cm[i]));
      chk($sformatf("tc[%0d]", i), int'(tcv[i]), int'(up_dn ? m_cnt[i] == 255 : m_cnt[i] == 0));
    end
  end

  initial begin
    rst_n = 0; en = 0; up_dn = 0; clear = 0; load = 0; oe = 0;
    load_val = 8'h00; cmp_val = 8'h00;
    repeat (3) tick();
    chk("rst_count_q", int'(cq[0]), 0);
    chk("rst_out_valid", int'(ov[0]), 0);
    chk("rst_wrap", int'(wp[1]), 0);
    rst_n = 1; up_dn = 1; en = 1;
    for (int k = 0; k < 256; k++) begin
      tick();
      chk("run_count", int'(cq[0]), (k + 1) % 256);
      chk("run_wrap", int'(wp[0]), int'(k == 255));
    end
    en = 0; load_val = 8'h05; load = 1; clear = 1;
    tick();
    chk("clear_over_load", int'(cq[0]), 0);
    clear = 0;
    tick();
    chk("load_only", int'(cq[0]), 5);
    load_val = 8'h01;
    tick();
    load = 0; up_dn = 0; en = 1;
    tick();
    chk("sat_down", int'(cq[1]), 0);
    chk("sat_nowrap", int'(wp[1]), 0);
    tick();
    chk("sat_hold", int'(cq[1]), 0);
    chk("sat_wrap", int'(wp[1]), 1);
    chk("sat_tc", int'(tcv[1]), 1);
    en = 0;
    tick();
    chk("sat_wrap_once", int'(wp[1]), 0);
    clear = 1;
    tick();
    clear = 0; up_dn = 1; en = 1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("pre_count", int'(cq[2]), k / 4);
    end
    repeat (2) tick();
    en = 0;
    repeat (2) tick();
    chk("pre_paused", int'(cq[2]), 3);
    en = 1;
    tick();
    chk("pre_delay", int'(cq[2]), 3);
    tick();
    chk("pre_step", int'(cq[2]), 4);
    en = 0; oe = 0;
    tick();
    chk("oe0_out", int'(co[0]), 0);
    chk("oe0_valid", int'(ov[0]), 0);
    load_val = 8'h2A; load = 1;
    tick();
    load = 0;
    chk("load_2a", int'(cq[0]), 42);
    oe = 1;
    tick();
    chk("oe1_out", int'(co[0]), 42);
    chk("oe1_valid", int'(ov[0]), 1);
    oe = 0;
    tick();
    chk("oe_drop_out", int'(co[0]), 0);
    chk("oe_drop_valid", int'(ov[0]), 0);
    cmp_val = 8'h10; load_val = 8'h0E; load = 1;
    tick();
    load = 0; up_dn = 1; en = 1;
    tick();
    chk("cmp_0f", int'(cm[0]), 0);
    tick();
    chk("cmp_10", int'(cm[0]), int'(CMP_ON));
    tick();
    chk("cmp_11", int'(cm[0]), 0);
    en = 0; load_val = 8'h10; load = 1;
    tick();
    load = 0;
    chk("cmp_load", int'(cm[1]), int'(CMP_ON));
    repeat (2) tick();
    chk("cmp_hold", int'(cm[1]), 0);
    en = 1;
    repeat (2) tick();
    rst_n = 0;
    #1;
    chk("midrst_count", int'(cq[0]), 0);
    chk("midrst_count2", int'(cq[2]), 0);
    tick();
    rst_n = 1; up_dn = 1; en = 1;
    repeat (3) tick();
    chk("post_rst_wait", int'(cq[2]), 0);
    tick();
    chk("post_rst_step", int'(cq[2]), 1);
    tick();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
